// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} bcd2bin_state_t;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam int BCD_NIBBLE_W = 4;
endpackage

// File: rtl/bcd_digit_mac.sv
// One fold step of decimal accumulation: acc*10 + digit, truncated to BIN_W.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0]        acc,
  input  logic [BCD_NIBBLE_W-1:0] digit,
  output logic [BIN_W-1:0]        acc_nxt,
  output logic                    digit_invalid
);
  // x*10 as x*8 + x*2; wrapping at BIN_W is the intended truncation
  assign acc_nxt       = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_invalid = (digit > BCD_DIGIT_MAX);
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Optional digit validity check enabled by defining BCD2BIN_ERR_EN.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BIN_W-1:0]               bin_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_err
);
  localparam int IN_W  = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd2bin_state_t          state, state_nxt;
  logic [IN_W-1:0]         shreg;
  logic [BIN_W-1:0]        acc, acc_nxt, bin_q, res_bin;
  logic [CNT_W-1:0]        cnt;
  logic [BCD_NIBBLE_W-1:0] digit;
  logic                    digit_invalid;
  logic                    accept, last;

  assign digit  = shreg[IN_W-1 -: BCD_NIBBLE_W];
  assign last   = (cnt == CNT_W'(DIGITS - 1));
  assign accept = in_valid && in_ready;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc           (acc),
    .digit         (digit),
    .acc_nxt       (acc_nxt),
    .digit_invalid (digit_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BCD2BIN_ERR_EN
  logic err, err_nxt, err_q;
  assign err_nxt = err | digit_invalid;
  // A bad digit anywhere in the word poisons the whole result
  assign res_bin = err_nxt ? '0 : acc_nxt;
  assign out_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err   <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (state == CONV) begin
      err <= err_nxt;
      if (last) err_q <= err_nxt;
    end
  end
`else
  logic unused_digit_invalid;
  assign unused_digit_invalid = digit_invalid;
  assign res_bin = acc_nxt;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      bin_q <= '0;
    end else if (accept) begin
      shreg <= bcd_in;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CONV) begin
      acc   <= acc_nxt;
      shreg <= shreg << BCD_NIBBLE_W;
      cnt   <= cnt + 1'b1;
      // result register only moves on the CONV->DONE edge
      if (last) bin_q <= res_bin;
    end
  end

  assign bin_out = bin_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (DIGITS=2, BIN_W=7).
module tb_bcd2bin_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] bin_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_err;

  int tests = 0;
  int fails = 0;

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // accept one word with out_ready=1, check latency and result, then handshake
  task automatic convert(input string tag, input logic [7:0] bcd,
                         input logic [6:0] exp_bin, input logic exp_err);
    bcd_in = bcd; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    tick();
    chk({tag, "_noval"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_val"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_bin"}, {25'd0, bin_out}, {25'd0, exp_bin});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    tick();
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; bcd_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin", {25'd0, bin_out}, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    convert("c36", 8'h36, 7'd36, 1'b0);
    chk("c36_hold_bin", {25'd0, bin_out}, 32'd36);
    chk("c36_out_low", {31'd0, out_valid}, 32'd0);

    // back-to-back: upstream keeps in_valid high and holds each word until taken
    bcd_in = 8'h13; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    bcd_in = 8'h57;
    chk("b2b_conv_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("b2b_conv_rdy2", {31'd0, in_ready}, 32'd0);
    tick();
    chk("b2b_v1", {31'd0, out_valid}, 32'd1);
    chk("b2b_bin1", {25'd0, bin_out}, 32'd13);
    chk("b2b_done_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("b2b_idle_rdy", {31'd0, in_ready}, 32'd1);
    chk("b2b_idle_val", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_conv2_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    chk("b2b_bin2", {25'd0, bin_out}, 32'd57);
    tick();

    // max value with backpressure
    bcd_in = 8'h99; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_bin", {25'd0, bin_out}, 32'd99);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_released", {31'd0, out_valid}, 32'd0);

`ifdef BCD2BIN_ERR_EN
    convert("c3A", 8'h3A, 7'd0, 1'b1);
    convert("cF0", 8'hF0, 7'd0, 1'b1);
    convert("c50_after_err", 8'h50, 7'd50, 1'b0);
`else
    convert("c3A", 8'h3A, 7'd40, 1'b0);
    convert("cF0", 8'hF0, 7'd22, 1'b0);
    convert("c50", 8'h50, 7'd50, 1'b0);
`endif
    convert("c00", 8'h00, 7'd0, 1'b0);
    convert("c09", 8'h09, 7'd9, 1'b0);

    // reset in the first CONV cycle
    bcd_in = 8'h42; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("rconv_rdy", {31'd0, in_ready}, 32'd1);
    chk("rconv_val", {31'd0, out_valid}, 32'd0);
    chk("rconv_bin", {25'd0, bin_out}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rconv_no_partial", {31'd0, out_valid}, 32'd0);
    end
    convert("c07", 8'h07, 7'd7, 1'b0);

    // reset while a result is pending
    bcd_in = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rdone_pending", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rdone_val", {31'd0, out_valid}, 32'd0);
    chk("rdone_bin", {25'd0, bin_out}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rdone_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
